// File: rtl/hpm_counters.sv
// Programmable hardware performance-monitor counters with per-counter event masks and inhibit.
// Define HPM_OVF_IRQ_EN to build the sticky overflow status register (address 62) and irq_o.
module hpm_counters #(
  parameter int unsigned NUM_COUNTERS = 8,
  parameter int unsigned NUM_EVENTS   = 16,
  parameter int unsigned CNT_WIDTH    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  debug_mode_i,
  input  logic [5:0]            addr_i,
  input  logic                  we_i,
  input  logic [63:0]           data_i,
  output logic [63:0]           data_o,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  irq_o
);

  localparam int unsigned INC_W = $clog2(NUM_EVENTS + 1);
  localparam int unsigned SUM_W = CNT_WIDTH + 1;
  localparam logic [5:0] ADDR_OVF     = 6'd62;
  localparam logic [5:0] ADDR_INHIBIT = 6'd63;
  localparam logic [5:0] ADDR_MASK0   = 6'd32;

  // Elaboration-time guard on the legal parameter ranges.
  if (NUM_COUNTERS < 1 || NUM_COUNTERS > 30) begin : g_bad_num_counters
    $error("hpm_counters: NUM_COUNTERS must be in 1..30");
  end
  if (NUM_EVENTS < 1 || NUM_EVENTS > 64) begin : g_bad_num_events
    $error("hpm_counters: NUM_EVENTS must be in 1..64");
  end
  if (CNT_WIDTH < 8 || CNT_WIDTH > 64) begin : g_bad_cnt_width
    $error("hpm_counters: CNT_WIDTH must be in 8..64");
  end

  logic [CNT_WIDTH-1:0]    cnt_q   [NUM_COUNTERS];
  logic [NUM_EVENTS-1:0]   mask_q  [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] inhibit_q;

  logic [SUM_W-1:0]        sum     [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] cnt_we;
  logic [NUM_COUNTERS-1:0] mask_we;
  logic [NUM_COUNTERS-1:0] count_en;
  logic [NUM_COUNTERS-1:0] carry;
  logic [NUM_COUNTERS-1:0] ovf_rd;
  logic                    inhibit_we;
  logic                    ovf_we;

  function automatic logic [INC_W-1:0] popcount(input logic [NUM_EVENTS-1:0] v);
    logic [INC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      n = n + INC_W'(v[i]);
    end
    return n;
  endfunction

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    inhibit_we = we_i && (addr_i == ADDR_INHIBIT);
    ovf_we     = we_i && (addr_i == ADDR_OVF);
    cnt_we     = '0;
    mask_we    = '0;
    count_en   = '0;
    carry      = '0;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      cnt_we[k]   = we_i && (addr_i == 6'(k));
      mask_we[k]  = we_i && (addr_i == ADDR_MASK0 + 6'(k));
      count_en[k] = !debug_mode_i && !inhibit_q[k];
      sum[k]      = {1'b0, cnt_q[k]} + SUM_W'(popcount(event_i & mask_q[k]));
      // A counter write discards the increment, so it can never raise an overflow.
      carry[k]    = count_en[k] && !cnt_we[k] && sum[k][CNT_WIDTH];
    end
  end

  // NOTE: the counter and mask arrays are architectural state with defined reset values,
  // so they are reset flops rather than an unreset RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        cnt_q[k]  <= '0;
        mask_q[k] <= '0;
      end
      inhibit_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        if (cnt_we[k]) begin
          cnt_q[k] <= data_i[CNT_WIDTH-1:0];
        end else if (count_en[k]) begin
          cnt_q[k] <= sum[k][CNT_WIDTH-1:0];
        end
        if (mask_we[k]) begin
          mask_q[k] <= data_i[NUM_EVENTS-1:0];
        end
      end
      if (inhibit_we) begin
        inhibit_q <= data_i[NUM_COUNTERS-1:0];
      end
    end
  end

`ifdef HPM_OVF_IRQ_EN
  logic [NUM_COUNTERS-1:0] ovf_q;
  logic [NUM_COUNTERS-1:0] ovf_d;
  logic                    irq_q;

  // A new carry overrides a simultaneous write-1-to-clear of the same bit.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_we) begin
      ovf_d = ovf_q & ~data_i[NUM_COUNTERS-1:0];
    end
    ovf_d = ovf_d | carry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= |ovf_d;
    end
  end

  assign ovf_rd = ovf_q;
  assign irq_o  = irq_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{carry, ovf_we};
  assign ovf_rd     = '0;
  assign irq_o      = 1'b0;
`endif

  // Read port: zero-extended, combinational, shows pre-write state during a write cycle.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      if (addr_i == 6'(k)) begin
        data_o = 64'(cnt_q[k]);
      end
      if (addr_i == ADDR_MASK0 + 6'(k)) begin
        data_o = 64'(mask_q[k]);
      end
    end
    if (addr_i == ADDR_OVF) begin
      data_o = 64'(ovf_rd);
    end
    if (addr_i == ADDR_INHIBIT) begin
      data_o = 64'(inhibit_q);
    end
  end

endmodule

// File: tb/tb_hpm_counters.sv
// Directed self-checking bench for hpm_counters at default parameters.
// Overflow expectations follow whether HPM_OVF_IRQ_EN is defined for the build.
module tb_hpm_counters;

`ifdef HPM_OVF_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        debug_mode_i;
  logic [5:0]  addr_i;
  logic        we_i;
  logic [63:0] data_i;
  logic [63:0] data_o;
  logic [15:0] event_i;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  hpm_counters dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .debug_mode_i (debug_mode_i),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .event_i      (event_i),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic apply_reset();
    rst_ni = 1'b0; debug_mode_i = 1'b0; addr_i = '0; we_i = 1'b0; data_i = '0; event_i = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic wr(input logic [5:0] a, input logic [63:0] d);
    @(negedge clk_i);
    addr_i = a; data_i = d; we_i = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0; data_i = '0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [63:0] d);
    addr_i = a;
    #1;
    d = data_o;
  endtask

  task automatic test_reset();
    logic [63:0] got;
    apply_reset();
    for (int a = 0; a < 64; a++) begin
      rd(6'(a), got);
      total++; if (got !== 64'd0) begin bad++; $display("FAIL reset_read addr=%0d got=%0h exp=0", a, got); end
    end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
  endtask

  task automatic test_count();
    logic [63:0] got;
    apply_reset();
    wr(6'd32, 64'h5);
    wr(6'd37, 64'hFFFF);
    event_i = 16'h0007;
    repeat (10) @(negedge clk_i);
    event_i = '0;
    rd(6'd0, got);
    total++; if (got !== 64'd20) begin bad++; $display("FAIL count_cnt0 got=%0d exp=20", got); end
    rd(6'd1, got);
    total++; if (got !== 64'd0) begin bad++; $display("FAIL count_cnt1 got=%0d exp=0", got); end
    rd(6'd5, got);
    total++; if (got !== 64'd30) begin bad++; $display("FAIL count_cnt5 got=%0d exp=30", got); end
    event_i = 16'hFFFF;
    @(negedge clk_i);
    event_i = '0;
    rd(6'd5, got);
    total++; if (got !== 64'd46) begin bad++; $display("FAIL count_all_events_cnt5 got=%0d exp=46", got); end
    rd(6'd0, got);
    total++; if (got !== 64'd22) begin bad++; $display("FAIL count_all_events_cnt0 got=%0d exp=22", got); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL count_irq got=%b exp=0", irq_o); end
  endtask

  task automatic test_overflow();
    logic [63:0] got;
    logic [63:0] exp;
    apply_reset();
    wr(6'd34, 64'hF);
    wr(6'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    rd(6'd62, got);
    total++; if (got !== 64'd0) begin bad++; $display("FAIL ovf_after_cnt_write got=%0h exp=0", got); end
    event_i = 16'h0003;
    @(negedge clk_i);
    event_i = '0;
    rd(6'd2, got);
    total++; if (got !== 64'd0) begin bad++; $display("FAIL ovf_cnt2_wrap got=%0h exp=0", got); end
    exp = OVF_EN ? 64'h4 : 64'h0;
    rd(6'd62, got);
    total++; if (got !== exp) begin bad++; $display("FAIL ovf_status got=%0h exp=%0h", got, exp); end
    total++; if (irq_o !== OVF_EN) begin bad++; $display("FAIL ovf_irq_set got=%b exp=%b", irq_o, OVF_EN); end
    repeat (3) @(negedge clk_i);
    total++; if (irq_o !== OVF_EN) begin bad++; $display("FAIL ovf_irq_sticky got=%b exp=%b", irq_o, OVF_EN); end
    wr(6'd62, 64'h4);
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL ovf_irq_w1c got=%b exp=0", irq_o); end
    rd(6'd62, got);
    total++; if (got !== 64'd0) begin bad++; $display("FAIL ovf_status_w1c got=%0h exp=0", got); end
  endtask

  task automatic test_inhibit_debug();
    logic [63:0] got;
    apply_reset();
    wr(6'd32, 64'h1);
    wr(6'd33, 64'h1);
    wr(6'd63, 64'h1);
    rd(6'd63, got);
    total++; if (got !== 64'h1) begin bad++; $display("FAIL inhibit_read got=%0h exp=1", got); end
    event_i = 16'h0001;
    @(negedge clk_i);
    debug_mode_i = 1'b1;
    repeat (2) @(negedge clk_i);
    debug_mode_i = 1'b0;
    repeat (2) @(negedge clk_i);
    event_i = '0;
    rd(6'd0, got);
    total++; if (got !== 64'd0) begin bad++; $display("FAIL inhibit_cnt0 got=%0d exp=0", got); end
    rd(6'd1, got);
    total++; if (got !== 64'd3) begin bad++; $display("FAIL debug_cnt1 got=%0d exp=3", got); end
  endtask

  task automatic test_write_collision();
    logic [63:0] got;
    apply_reset();
    wr(6'd35, 64'h1);
    event_i = 16'h0001;
    repeat (3) @(negedge clk_i);
    addr_i = 6'd3; data_i = 64'd100; we_i = 1'b1;
    #1;
    got = data_o;
    total++; if (got !== 64'd3) begin bad++; $display("FAIL wr_cycle_old_value got=%0d exp=3", got); end
    @(negedge clk_i);
    we_i = 1'b0; data_i = '0; event_i = '0;
    rd(6'd3, got);
    total++; if (got !== 64'd100) begin bad++; $display("FAIL wr_wins_cnt3 got=%0d exp=100", got); end
  endtask

  task automatic test_mask_timing();
    logic [63:0] got;
    apply_reset();
    @(negedge clk_i);
    event_i = 16'h0001; addr_i = 6'd38; data_i = 64'h1; we_i = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0; data_i = '0;
    @(negedge clk_i);
    event_i = '0;
    rd(6'd6, got);
    total++; if (got !== 64'd1) begin bad++; $display("FAIL mask_next_cycle_cnt6 got=%0d exp=1", got); end
    wr(6'd32, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(6'd32, got);
    total++; if (got !== 64'hFFFF) begin bad++; $display("FAIL mask_trunc got=%0h exp=ffff", got); end
    wr(6'd63, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(6'd63, got);
    total++; if (got !== 64'hFF) begin bad++; $display("FAIL inhibit_trunc got=%0h exp=ff", got); end
    wr(6'd40, 64'h1234);
    rd(6'd40, got);
    total++; if (got !== 64'd0) begin bad++; $display("FAIL unmapped_40 got=%0h exp=0", got); end
    wr(6'd10, 64'h5678);
    rd(6'd10, got);
    total++; if (got !== 64'd0) begin bad++; $display("FAIL unmapped_10 got=%0h exp=0", got); end
  endtask

  task automatic test_ovf_collision();
    logic [63:0] got;
    logic [63:0] exp;
    apply_reset();
    wr(6'd36, 64'h1);
    wr(6'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk_i);
    event_i = 16'h0001; addr_i = 6'd62; data_i = 64'h10; we_i = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0; data_i = '0; event_i = '0;
    rd(6'd4, got);
    total++; if (got !== 64'd0) begin bad++; $display("FAIL coll_cnt4_wrap got=%0h exp=0", got); end
    exp = OVF_EN ? 64'h10 : 64'h0;
    rd(6'd62, got);
    total++; if (got !== exp) begin bad++; $display("FAIL coll_set_wins got=%0h exp=%0h", got, exp); end
    total++; if (irq_o !== OVF_EN) begin bad++; $display("FAIL coll_irq got=%b exp=%b", irq_o, OVF_EN); end
  endtask

  task automatic test_reset_midop();
    logic [63:0] got;
    apply_reset();
    wr(6'd32, 64'h1);
    event_i = 16'h0001;
    repeat (4) @(negedge clk_i);
    rd(6'd0, got);
    total++; if (got !== 64'd4) begin bad++; $display("FAIL midop_before got=%0d exp=4", got); end
    #2 rst_ni = 1'b0;
    rd(6'd0, got);
    total++; if (got !== 64'd0) begin bad++; $display("FAIL midop_async_clear got=%0d exp=0", got); end
    @(negedge clk_i);
    event_i = '0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    rd(6'd32, got);
    total++; if (got !== 64'd0) begin bad++; $display("FAIL midop_mask_clear got=%0h exp=0", got); end
    rd(6'd0, got);
    total++; if (got !== 64'd0) begin bad++; $display("FAIL midop_cnt_after got=%0d exp=0", got); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_overflow();
    test_inhibit_debug();
    test_write_collision();
    test_mask_timing();
    test_ovf_collision();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpm_counters.md
# hpm_counters

Parametrised hardware performance-monitor block: `NUM_COUNTERS` programmable counters, each with its own event-select mask over `NUM_EVENTS` single-cycle event pulses. It adds per-counter inhibit, multi-event-per-cycle accumulation (popcount), and sticky overflow status with an interrupt. It sits beside the CSR file and is accessed through the same SRAM-like read/write port as the fixed-function performance counters. Event sources are commit ports, caches, MMU, issue stage and frontend.

## Interface
Parameters:
- `NUM_COUNTERS`, 8: number of programmable counters; legal range 1..30.
- `NUM_EVENTS`, 16: width of the event vector; legal range 1..64.
- `CNT_WIDTH`, 64: counter width; legal range 8..64.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `debug_mode_i`  in  1  while high, no counter increments.
- `addr_i`  in  6  register address.
- `we_i`  in  1  write enable.
- `data_i`  in  64  write data.
- `data_o`  out  64  read data; combinational from current register state.
- `event_i`  in  `NUM_EVENTS`  event pulses; each bit high means one occurrence this cycle.
- `irq_o`  out  1  overflow interrupt, registered.

## Operation
- Address map:
  - `0..NUM_COUNTERS-1`: counter k.
  - `32..32+NUM_COUNTERS-1`: event mask k, in bits `[NUM_EVENTS-1:0]`.
  - `62`: overflow status, one bit per counter, write-1-to-clear.
  - `63`: inhibit, one bit per counter.
  - All other addresses read 0; writes to them are ignored.
- Increment for counter k: `inc_k = popcount(event_i & mask_k)`, width `$clog2(NUM_EVENTS+1)`.
- Counter k adds `inc_k` unless `debug_mode_i` is high or `inhibit[k]` is set.
- Counters wrap modulo `2^CNT_WIDTH`. A carry out of bit `CNT_WIDTH-1` sets `ovf[k]`.
- Read behaviour:
  - `data_o` is zero-extended counter, mask, or status.
  - Bits above `NUM_COUNTERS` or `NUM_EVENTS` read 0.
- Write behaviour:
  - A write truncates `data_i` to the register width.
  - Write-after-read: `data_o` in the write cycle shows the old value.
- Simultaneous events:
  - Write to counter k and increment in the same cycle: the write wins and the increment is lost.
  - Write to mask k: the new mask applies from the next cycle. The current cycle uses the old mask.
  - Write to inhibit: takes effect the next cycle.
  - W1C of `ovf[k]` in the same cycle as a new overflow of k: the set wins.
  - A write to counter k never sets `ovf[k]`.
- `irq_o = |ovf_q`.
- Reset values: all counters, masks, inhibit, `ovf` and `irq_o` are 0. `data_o` = 0 for any address.
- Reset mid-operation clears all state asynchronously. No partial increment survives.

## Timing
- Event sampled in cycle N: counter value visible on `data_o` in cycle N+1.
- Overflow in cycle N: `ovf[k]` and `irq_o` high from cycle N+1.
- W1C in cycle N: `irq_o` low from N+1, provided no other `ovf` bit is set.
- Read latency: 0 cycles (combinational).
- Write latency: 1 cycle.
- No stall or handshake; one access per cycle.
- The counter adder is a single-cycle `CNT_WIDTH` add. No pipelining.

## Configuration
- `HPM_OVF_IRQ_EN` defined:
  - Overflow status register and `irq_o` implemented as above.
- `HPM_OVF_IRQ_EN` undefined:
  - No `ovf` flops; address 62 reads 0 and writes to it are ignored.
  - `irq_o` is tied 0.
  - Counters still wrap silently.

## Test plan
- Reset, then read all 64 addresses -> every read returns 0; `irq_o` = 0.
- Mask0 = 0x0005, `event_i` = 0x0007 for 10 cycles -> counter0 = 20. Counter1 (mask 0) = 0.
- Counter2 = `2^CNT_WIDTH - 2`, mask2 = 0x000F, `event_i` = 0x0003 for 1 cycle:
  - Next cycle: counter2 = 0, `ovf[2]` = 1, `irq_o` = 1.
  - Then write 0x4 to address 62 -> `irq_o` = 0 the following cycle.
- Inhibit = 0x1 and `debug_mode_i` pulsed with mask0 = mask1 = 0x1, `event_i` = 0x1 for 5 cycles, debug high for 2 of them:
  - Counter0 stays 0.
  - Counter1 = 3.
- Write counter3 = 100 in the same cycle `event_i` hits mask3 -> counter3 = 100. `data_o` in the write cycle shows the old value.
- Overflow of counter4 in the same cycle as a W1C of bit 4 -> `ovf[4]` stays 1 and `irq_o` stays 1. Without `HPM_OVF_IRQ_EN`, the same stimulus gives `irq_o` = 0 and address 62 reads 0.
